// File: rtl/vertex_pkg.sv
// Shared types and arithmetic helpers for the sequential vertex transform.
// Helpers take DATA_W/FRAC_W as arguments so every instance can share them.
package vertex_pkg;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

    localparam int          N_ROWS   = 4;
    localparam int          N_COLS   = 4;
    localparam int          IDX_W    = 4;
    localparam logic [1:0]  LAST_COL = 2'd3;
    localparam logic [1:0]  FIRST_ROW = 2'd0;
    localparam logic [3:0]  LAST_IDX = 4'd15;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] val;
    } rs_t;

    // Identity matrix entry for index row*4+col.
    function automatic logic [63:0] ident_entry(logic [3:0] idx, int unsigned frac_w);
        return (idx[3:2] == idx[1:0]) ? (64'd1 << frac_w) : 64'd0;
    endfunction

    // Round half up, then clamp to the signed data_w range.
    function automatic rs_t round_sat(logic signed [63:0] acc, int unsigned data_w,
                                      int unsigned frac_w);
        logic signed [63:0] r, hi, lo;
        rs_t o;
        r     = (acc + (64'sd1 <<< (frac_w - 1))) >>> frac_w;
        hi    = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo    = -(64'sd1 <<< (data_w - 1));
        o.sat = 1'b0;
        o.val = r;
        if (r > hi) begin
            o.sat = 1'b1;
            o.val = hi;
        end else if (r < lo) begin
            o.sat = 1'b1;
            o.val = lo;
        end
        return o;
    endfunction

endpackage

// File: rtl/vertex_mac.sv
// Shared signed multiply-accumulate with a rounded, saturated view of the
// running sum including the current product (used on the row-commit cycle).
module vertex_mac
    import vertex_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res,
    output logic              sat
);

    localparam int AW = 2 * DATA_W + 2;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [AW-1:0]       acc_q, acc_d, sum;
    rs_t                        rs;

    assign prod = $signed(a) * $signed(b);
    assign sum  = acc_q + {{2{prod[2*DATA_W-1]}}, prod};
    assign rs   = round_sat({{(64-AW){sum[AW-1]}}, sum}, DATA_W, FRAC_W);
    assign res  = DATA_W'(rs.val);
    assign sat  = rs.sat;

    always_comb begin
        acc_d = acc_q;
        if (clr)
            acc_d = '0;
        else if (en)
            acc_d = sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

endmodule

// File: rtl/vertex_transform_seq.sv
// 4x4 matrix times (X,Y,Z,W) vertex using one MAC over 16 cycles per vertex,
// with a writable matrix bank and valid/ready handshakes on both sides.
module vertex_transform_seq
    import vertex_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mat_we,
    input  logic [3:0]        mat_addr,
    input  logic [DATA_W-1:0] mat_wdata,
    output logic              mat_ready,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,
    input  logic [DATA_W-1:0] in_z,
    input  logic [DATA_W-1:0] in_w,
    input  logic              use_w,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_p,
    output logic [DATA_W-1:0] out_q,
    output logic [DATA_W-1:0] out_r,
    output logic [DATA_W-1:0] out_s,
    output logic              out_sat
);

    localparam logic [DATA_W-1:0] ONE = DATA_W'(ident_entry(4'd0, FRAC_W));

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          rc_q, rc_d;
    logic [15:0][DATA_W-1:0]   mat_q;
    logic [3:0][DATA_W-1:0]    v_q, res_q;
    logic                      sat_q;
    logic                      idle_rdy, accept, commit;
    logic                      mac_clr, mac_en, mac_sat;
    logic [DATA_W-1:0]         mac_res;

    // Handshakes stay low for the whole time reset is held.
    assign idle_rdy  = (state_q == IDLE) && !rst;
    assign in_ready  = idle_rdy;
    assign mat_ready = idle_rdy;
    assign accept    = in_valid && idle_rdy;
    assign commit    = (state_q == MAC) && (rc_q[1:0] == LAST_COL);

    always_comb begin
        state_d   = state_q;
        rc_d      = rc_q;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = MAC;
                    rc_d    = '0;
                    mac_clr = 1'b1;
                end
            end
            MAC: begin
                mac_en  = 1'b1;
                mac_clr = (rc_q[1:0] == LAST_COL);
                rc_d    = rc_q + 4'd1;
                if (rc_q == LAST_IDX)
                    state_d = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            v_q <= '0;
        else if (accept)
            v_q <= {(use_w ? in_w : ONE), in_z, in_y, in_x};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++)
                mat_q[i] <= DATA_W'(ident_entry(4'(i), FRAC_W));
        end else if (mat_we && idle_rdy) begin
            mat_q[mat_addr] <= mat_wdata;
        end
    end

    // Row 0 restarts the sticky saturation flag so out_* only move on commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
            sat_q <= 1'b0;
        end else if (commit) begin
            res_q[rc_q[3:2]] <= mac_res;
            sat_q            <= (rc_q[3:2] == FIRST_ROW) ? mac_sat : (sat_q | mac_sat);
        end
    end

    vertex_mac #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (mat_q[rc_q]),
        .b   (v_q[rc_q[1:0]]),
        .res (mac_res),
        .sat (mac_sat)
    );

    assign out_p   = res_q[0];
    assign out_q   = res_q[1];
    assign out_r   = res_q[2];
    assign out_s   = res_q[3];
    assign out_sat = sat_q;

endmodule
